// File: rtl/anc_sample_feeder.sv
// anc_sample_feeder: FIFO + valid/ready producer feeding ADC sample triples
// (e, x, a) and the LMS step size into the ANC core, with an in-flight limit.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   init_done           core initialised; streaming only while high
//   adc_valid, adc_e/x/a, u_cfg
//                       one-cycle push strobe and the entry fields
//   ovf_clr             clears the sticky overflow / unexp_out flags
//   in_valid, controller_ready
//                       handshake toward the controller
//   e_out, x_out, a_out, u_out
//                       first-word fall-through head of the FIFO
//   out_valid           FIR output strobe; retires one in-flight sample
//   fifo_level          entries held, 0..DEPTH
//   overflow            sticky: a push was dropped on a full FIFO
//   unexp_out           sticky: out_valid arrived with nothing in flight
//
// Optional build macro ANC_FEEDER_STATS_EN adds the saturating
// drop_cnt / stall_cnt outputs.

module anc_sample_feeder #(
   parameter int DEPTH   = 4,
   parameter int AW      = 2,
   parameter int MAX_OUT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          init_done,
   input  logic          adc_valid,
   input  logic [15:0]   adc_e,
   input  logic [15:0]   adc_x,
   input  logic [15:0]   adc_a,
   input  logic [15:0]   u_cfg,
   input  logic          ovf_clr,
   output logic          in_valid,
   input  logic          controller_ready,
   output logic [15:0]   e_out,
   output logic [15:0]   x_out,
   output logic [15:0]   a_out,
   output logic [15:0]   u_out,
   input  logic          out_valid,
   output logic [AW:0]   fifo_level,
   output logic          overflow,
   output logic          unexp_out
`ifdef ANC_FEEDER_STATS_EN
   ,
   output logic [15:0]   drop_cnt,
   output logic [15:0]   stall_cnt
`endif
);

   typedef enum logic {
      WAIT_INIT,
      RUN
   } state_t;

   typedef struct packed {
      logic [15:0] e;
      logic [15:0] x;
      logic [15:0] a;
      logic [15:0] u;
   } entry_t;

   state_t      state;
   state_t      state_nxt;
   entry_t      mem [DEPTH];
   entry_t      head;
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [2:0]  inflight;
   logic        full;
   logic        empty;
   logic        can_issue;
   logic        pop;
   logic        push;
   logic        drop;
   logic        unexp_ev;

   // ---------------- control FSM ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= WAIT_INIT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         WAIT_INIT: if (init_done)  state_nxt = RUN;
         RUN:       if (!init_done) state_nxt = WAIT_INIT;
         default:   state_nxt = WAIT_INIT;
      endcase
   end

   // ---------------- FIFO status ----------------
   // Pointers carry one extra bit so full and empty are distinguishable.
   assign fifo_level = wr_ptr - rd_ptr;
   assign full       = (fifo_level == (AW+1)'(DEPTH));
   assign empty      = (fifo_level == '0);
   assign can_issue  = (inflight < 3'(MAX_OUT));

   // Depends only on registered state, so it cannot glitch with ready.
   assign in_valid = (state == RUN) & ~empty & can_issue;

   assign pop      = in_valid & controller_ready;
   // A pop frees the slot in the same cycle, so a full FIFO still accepts.
   assign push     = adc_valid & (~full | pop);
   assign drop     = adc_valid & full & ~pop;
   assign unexp_ev = out_valid & (inflight == 3'd0);

   assign head  = mem[rd_ptr[AW-1:0]];
   assign e_out = head.e;
   assign x_out = head.x;
   assign a_out = head.a;
   assign u_out = head.u;

   // ---------------- storage and pointers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{e: adc_e, x: adc_x, a: adc_a, u: u_cfg};
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // ---------------- in-flight accounting ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= 3'd0;
      end else begin
         unique case ({pop, out_valid})
            2'b10:   inflight <= inflight + 3'd1;
            2'b01:   if (inflight != 3'd0) inflight <= inflight - 3'd1;
            default: inflight <= inflight;
         endcase
      end
   end

   // ---------------- sticky flags (set beats clear) ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         unexp_out <= 1'b0;
      end else begin
         if (drop)         overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
         if (unexp_ev)     unexp_out <= 1'b1;
         else if (ovf_clr) unexp_out <= 1'b0;
      end
   end

`ifdef ANC_FEEDER_STATS_EN
   // ---------------- saturating statistics ----------------
   always_ff @(posedge clk) begin
      if (rst || ovf_clr) begin
         drop_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (drop && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
         if (in_valid && !controller_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_anc_sample_feeder.sv
// tb_anc_sample_feeder: directed scenarios plus randomized traffic for
// anc_sample_feeder, checked every cycle against a queue-based model.

module tb_anc_sample_feeder;

   localparam int DEPTH   = 4;
   localparam int AW      = 2;
   localparam int MAX_OUT = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        init_done = 1'b0;
   logic        adc_valid = 1'b0;
   logic [15:0] adc_e = '0;
   logic [15:0] adc_x = '0;
   logic [15:0] adc_a = '0;
   logic [15:0] u_cfg = '0;
   logic        ovf_clr = 1'b0;
   logic        in_valid;
   logic        controller_ready = 1'b0;
   logic [15:0] e_out;
   logic [15:0] x_out;
   logic [15:0] a_out;
   logic [15:0] u_out;
   logic        out_valid = 1'b0;
   logic [AW:0] fifo_level;
   logic        overflow;
   logic        unexp_out;

   anc_sample_feeder #(.DEPTH(DEPTH), .AW(AW), .MAX_OUT(MAX_OUT)) dut (
      .clk              (clk),
      .rst              (rst),
      .init_done        (init_done),
      .adc_valid        (adc_valid),
      .adc_e            (adc_e),
      .adc_x            (adc_x),
      .adc_a            (adc_a),
      .u_cfg            (u_cfg),
      .ovf_clr          (ovf_clr),
      .in_valid         (in_valid),
      .controller_ready (controller_ready),
      .e_out            (e_out),
      .x_out            (x_out),
      .a_out            (a_out),
      .u_out            (u_out),
      .out_valid        (out_valid),
      .fifo_level       (fifo_level),
      .overflow         (overflow),
      .unexp_out        (unexp_out)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      else
         n_pass++;
   endtask

   // ---------------- reference model ----------------
   logic [63:0] q[$];
   int          m_inf = 0;
   bit          m_run = 0;
   bit          m_ovf = 0;
   bit          m_unx = 0;
   bit          m_iv, m_pop, m_drop, m_uev;
   logic [63:0] m_tmp;

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_inf = 0;
         m_run = 0;
         m_ovf = 0;
         m_unx = 0;
      end else begin
         m_iv   = m_run && q.size() != 0 && m_inf < MAX_OUT;
         m_pop  = m_iv && controller_ready;
         m_drop = adc_valid && q.size() == DEPTH && !m_pop;
         m_uev  = out_valid && m_inf == 0;
         if (m_pop) m_tmp = q.pop_front();
         if (adc_valid && !m_drop) q.push_back({adc_e, adc_x, adc_a, u_cfg});
         m_ovf = m_drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
         m_unx = m_uev ? 1'b1 : (ovf_clr ? 1'b0 : m_unx);
         if (m_pop && !out_valid) m_inf++;
         else if (!m_pop && out_valid && m_inf > 0) m_inf--;
         m_run = init_done;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("m_in_valid", 64'(in_valid),
               64'(m_run && q.size() != 0 && m_inf < MAX_OUT));
         check("m_level", 64'(fifo_level), 64'(q.size()));
         check("m_overflow", 64'(overflow), 64'(m_ovf));
         check("m_unexp", 64'(unexp_out), 64'(m_unx));
         if (q.size() != 0)
            check("m_head", {e_out, x_out, a_out, u_out}, q[0]);
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic set_push(input logic [15:0] e);
      adc_valid = 1'b1;
      adc_e = e;
      adc_x = e ^ 16'h5A5A;
      adc_a = ~e;
      u_cfg = e + 16'h0100;
   endtask

   logic [15:0] drain_exp [4];

   initial begin
      drain_exp[0] = 16'h0041;
      drain_exp[1] = 16'h0042;
      drain_exp[2] = 16'h0043;
      drain_exp[3] = 16'h0050;

      // T1 reset
      cyc();
      chk_en = 1'b1;
      cyc();
      check("t1_rst_valid", 64'(in_valid), 64'd0);
      check("t1_rst_level", 64'(fifo_level), 64'd0);
      check("t1_rst_flags", {62'd0, overflow, unexp_out}, 64'd0);
      check("t1_rst_head", {e_out, x_out, a_out, u_out}, 64'd0);
      rst = 1'b0;
      set_push(16'h1111);
      cyc();
      set_push(16'h2222);
      cyc();
      adc_valid = 1'b0;
      cyc();
      check("t1_level2", 64'(fifo_level), 64'd2);
      check("t1_no_valid", 64'(in_valid), 64'd0);

      // T2 stream
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      init_done = 1'b1;
      cyc();
      set_push(16'h0123);
      controller_ready = 1'b1;
      cyc();
      adc_valid = 1'b0;
      check("t2_valid", 64'(in_valid), 64'd1);
      check("t2_e", 64'(e_out), 64'h0123);
      cyc();
      check("t2_after_xfer", 64'(in_valid), 64'd0);
      cyc();
      check("t2_limit", 64'(in_valid), 64'd0);
      controller_ready = 1'b0;
      out_valid = 1'b1;
      cyc();
      out_valid = 1'b0;

      // T3 backpressure
      set_push(16'hFFFB);
      cyc();
      adc_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("t3_hold_valid", 64'(in_valid), 64'd1);
         check("t3_hold_e", 64'(e_out), 64'hFFFB);
         cyc();
      end
      controller_ready = 1'b1;
      cyc();
      controller_ready = 1'b0;
      check("t3_one_xfer", {63'd0, in_valid}, 64'd0);
      check("t3_level", 64'(fifo_level), 64'd0);
      out_valid = 1'b1;
      cyc();
      out_valid = 1'b0;

      // T4 overflow
      for (int i = 0; i < 5; i++) begin
         set_push(16'h0040 + 16'(i));
         cyc();
      end
      adc_valid = 1'b0;
      check("t4_full", 64'(fifo_level), 64'd4);
      check("t4_ovf", 64'(overflow), 64'd1);
      check("t4_head", 64'(e_out), 64'h0040);
      ovf_clr = 1'b1;
      cyc();
      ovf_clr = 1'b0;
      check("t4_ovf_clr", 64'(overflow), 64'd0);
      set_push(16'h0050);
      controller_ready = 1'b1;
      cyc();
      adc_valid = 1'b0;
      controller_ready = 1'b0;
      check("t4_pp_level", 64'(fifo_level), 64'd4);
      check("t4_pp_noovf", 64'(overflow), 64'd0);
      for (int k = 0; k < 4; k++) begin
         out_valid = 1'b1;
         cyc();
         out_valid = 1'b0;
         check("t4_drain_valid", 64'(in_valid), 64'd1);
         check("t4_drain_e", 64'(e_out), 64'(drain_exp[k]));
         controller_ready = 1'b1;
         cyc();
         controller_ready = 1'b0;
      end
      check("t4_empty", 64'(fifo_level), 64'd0);

      // T5 retire edge cases
      out_valid = 1'b1;
      cyc();
      cyc();
      out_valid = 1'b0;
      check("t5_unexp", 64'(unexp_out), 64'd1);
      ovf_clr = 1'b1;
      cyc();
      ovf_clr = 1'b0;
      check("t5_clr", {62'd0, overflow, unexp_out}, 64'd0);
      set_push(16'h0060);
      cyc();
      set_push(16'h0061);
      cyc();
      adc_valid = 1'b0;
      controller_ready = 1'b1;
      out_valid = 1'b1;
      cyc();
      controller_ready = 1'b0;
      out_valid = 1'b0;
      check("t5_same_level", 64'(fifo_level), 64'd1);
      check("t5_same_cnt", 64'(in_valid), 64'd1);
      check("t5_same_head", 64'(e_out), 64'h0061);
      ovf_clr = 1'b1;
      cyc();
      ovf_clr = 1'b0;

      // T6 init_done drop
      check("t6_pre_valid", 64'(in_valid), 64'd1);
      init_done = 1'b0;
      cyc();
      check("t6_drop_valid", 64'(in_valid), 64'd0);
      check("t6_drop_level", 64'(fifo_level), 64'd1);
      init_done = 1'b1;
      cyc();
      check("t6_re_valid", 64'(in_valid), 64'd1);
      check("t6_re_head", 64'(e_out), 64'h0061);
      controller_ready = 1'b1;
      cyc();
      controller_ready = 1'b0;
      out_valid = 1'b1;
      cyc();
      out_valid = 1'b0;

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst              = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 49) == 0) init_done = ~init_done;
         adc_valid        = $urandom_range(0, 1) == 1;
         adc_e            = 16'($urandom);
         adc_x            = 16'($urandom);
         adc_a            = 16'($urandom);
         u_cfg            = 16'($urandom);
         controller_ready = $urandom_range(0, 1) == 1;
         out_valid        = $urandom_range(0, 9) < 3;
         ovf_clr          = $urandom_range(0, 19) == 0;
         cyc();
      end
      rst = 1'b0;
      adc_valid = 1'b0;
      out_valid = 1'b0;
      ovf_clr = 1'b0;
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
